// File: rtl/skew_stim_gen_pkg.sv
// Shared types, defaults and helpers for the skew stimulus generator.
// abs_sat is only called when SKEW_STIM_NEG_EN is defined.
package skew_stim_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int CNT_W_DEF = 8;
   localparam int LIMIT_DEF = 2;

   // Magnitude of a w-bit two's complement value held sign-extended in 32 bits;
   // the most negative value saturates to the largest positive one.
   function automatic logic [31:0] abs_sat(input logic signed [31:0] v, input int w);
      logic signed [31:0] min_v;
      min_v = -(32'sd1 <<< (w - 1));
      if (v == min_v)
         return (32'd1 << (w - 1)) - 32'd1;
      else if (v < 0)
         return 32'(-v);
      else
         return 32'(v);
   endfunction

endpackage

// File: rtl/skew_stim_gen_if.sv
// Request/response bundle of the skew stimulus generator.
// master = requester side, slave = generator side.
interface skew_stim_gen_if
   import skew_stim_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) ();

   logic             start;
   logic [CNT_W-1:0] skew;
   logic [CNT_W-1:0] hold;
   logic             out_a;
   logic             out_b;
   logic             busy;
   logic             done;
   logic             exp_viol;

   modport master (
      output start, skew, hold,
      input  out_a, out_b, busy, done, exp_viol
   );

   modport slave (
      input  start, skew, hold,
      output out_a, out_b, busy, done, exp_viol
   );

endinterface

// File: rtl/skew_stim_pulse.sv
// Registered pulse shaper: output is high on the cycle after the edge where
// en is set and t lies in [off, off+len).
module skew_stim_pulse
   import skew_stim_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W:0]   t,
   input  logic [CNT_W-1:0] off,
   input  logic [CNT_W-1:0] len,
   output logic             pulse
);

   logic           pulse_q;
   logic           pulse_d;
   logic [CNT_W:0] lo;
   logic [CNT_W:0] hi;

   always_comb begin
      lo      = {1'b0, off};
      hi      = {1'b0, off} + {1'b0, len};
      pulse_d = en && (t >= lo) && (t < hi);
   end

   // NOTE: sequential state is written with <= so every flop samples the
   // values from before the edge, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) pulse_q <= 1'b0;
      else     pulse_q <= pulse_d;
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/skew_stim_gen.sv
// Skew stimulus generator: emits out_a/out_b pulses with programmable offset
// and width. Define SKEW_STIM_NEG_EN for a signed skew (negative => out_b leads).
module skew_stim_gen
   import skew_stim_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int LIMIT = LIMIT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   skew_stim_gen_if.slave  bus
);

   localparam int T_W = CNT_W + 1;
   localparam logic [T_W-1:0] LIMIT_V = T_W'(LIMIT);

   state_t           state_q, state_d;
   logic [T_W-1:0]   t_q, t_d;
   logic [CNT_W-1:0] s_q, s_d;
   logic [CNT_W-1:0] h_q, h_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             viol_q, viol_d;
   logic [CNT_W-1:0] skew_mag;
   logic [CNT_W-1:0] off_a_d;
   logic [CNT_W-1:0] off_b_d;
   logic             run_d;

`ifdef SKEW_STIM_NEG_EN
   logic neg_q, neg_d;

   always_comb begin
      skew_mag = CNT_W'(abs_sat(32'(signed'(bus.skew)), CNT_W));
      off_a_d  = neg_d ? s_d : '0;
      off_b_d  = neg_d ? '0  : s_d;
   end

   always_ff @(posedge clk) begin
      if (rst) neg_q <= 1'b0;
      else     neg_q <= neg_d;
   end
`else
   always_comb begin
      skew_mag = bus.skew;
      off_a_d  = '0;
      off_b_d  = s_d;
   end
`endif

   // NOTE: every variable gets its default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      s_d     = s_q;
      h_d     = h_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      viol_d  = viol_q;
`ifdef SKEW_STIM_NEG_EN
      neg_d   = neg_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               t_d     = '0;
               s_d     = skew_mag;
               h_d     = (bus.hold == '0) ? CNT_W'(1) : bus.hold;
               busy_d  = 1'b1;
               viol_d  = {1'b0, skew_mag} < LIMIT_V;
`ifdef SKEW_STIM_NEG_EN
               neg_d   = bus.skew[CNT_W-1];
`endif
            end
         end
         RUN: begin
            t_d = t_q + T_W'(1);
            if (t_d == ({1'b0, s_q} + {1'b0, h_q})) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      run_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         t_q     <= '0;
         s_q     <= '0;
         h_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         viol_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         s_q     <= s_d;
         h_q     <= h_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         viol_q  <= viol_d;
      end
   end

   // Shapers see next-state count and operands so outputs toggle on the same
   // edge that the FSM accepts or advances.
   skew_stim_pulse #(.CNT_W(CNT_W)) u_pulse_a (
      .clk   (clk),
      .rst   (rst),
      .en    (run_d),
      .t     (t_d),
      .off   (off_a_d),
      .len   (h_d),
      .pulse (bus.out_a)
   );

   skew_stim_pulse #(.CNT_W(CNT_W)) u_pulse_b (
      .clk   (clk),
      .rst   (rst),
      .en    (run_d),
      .t     (t_d),
      .off   (off_b_d),
      .len   (h_d),
      .pulse (bus.out_b)
   );

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.exp_viol = viol_q;

endmodule

// File: tb/tb_skew_stim_gen.sv
// Directed bench for skew_stim_gen; expected waveforms are hand-written bit
// masks where bit i is the value sampled after edge k+i.
module tb_skew_stim_gen;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   skew_stim_gen_if #(.CNT_W(8)) bus ();

   skew_stim_gen #(.CNT_W(8), .LIMIT(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Request at the current point (between a negedge and the next posedge),
   // then sample {out_a,out_b,busy,done} for n cycles.
   task automatic do_pulse(input string tag, input logic [7:0] sk, input logic [7:0] hd,
                           input int n, input logic [15:0] ea, input logic [15:0] eb,
                           input logic [15:0] ebusy, input logic [15:0] edone,
                           input logic ev, input logic keep_start);
      bus.start = 1'b1;
      bus.skew  = sk;
      bus.hold  = hd;
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (!keep_start) bus.start = 1'b0;
         check($sformatf("%s[%0d]", tag, i),
               {bus.out_a, bus.out_b, bus.busy, bus.done},
               {ea[i], eb[i], ebusy[i], edone[i]});
         if (i == 0) check({tag, "_viol"}, bus.exp_viol, ev);
      end
      bus.start = 1'b0;
   endtask

   task automatic reset_run(input string tag, input logic [7:0] sk, input logic [7:0] hd,
                            input logic [3:0] exp0, input logic ev);
      logic [4:0] seen;
      bus.start = 1'b1;
      bus.skew  = sk;
      bus.hold  = hd;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, "_k0"}, {bus.out_a, bus.out_b, bus.busy, bus.done}, exp0);
      check({tag, "_viol"}, bus.exp_viol, ev);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check({tag, "_after_rst"},
            {bus.out_a, bus.out_b, bus.busy, bus.done, bus.exp_viol}, 5'b0);
      seen = '0;
      repeat (10) begin
         @(negedge clk);
         seen |= {bus.out_a, bus.out_b, bus.busy, bus.done, bus.exp_viol};
      end
      check({tag, "_quiet"}, seen, 5'b0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.skew  = 8'd1;
      bus.hold  = 8'd1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_with_start",
            {bus.out_a, bus.out_b, bus.busy, bus.done, bus.exp_viol}, 5'b0);
      rst       = 1'b0;
      bus.start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("idle[%0d]", i),
               {bus.out_a, bus.out_b, bus.busy, bus.done, bus.exp_viol}, 5'b0);
      end

      // skew=1 hold=3: a k..k+2, b k+1..k+3, done k+4
      do_pulse("s1h3", 8'd1, 8'd3, 6,
               16'b000111, 16'b001110, 16'b001111, 16'b010000, 1'b1, 1'b0);
      // skew=5 hold=2: 3-cycle gap, done k+7
      do_pulse("s5h2", 8'd5, 8'd2, 9,
               16'b000000011, 16'b001100000, 16'b001111111, 16'b010000000, 1'b0, 1'b0);
      // skew=0 hold=0: one simultaneous cycle, done k+1
      do_pulse("s0h0", 8'd0, 8'd0, 3,
               16'b001, 16'b001, 16'b001, 16'b010, 1'b1, 1'b0);
      // start held high: accepts every s+h+1 = 3 cycles
      do_pulse("b2b", 8'd1, 8'd1, 9,
               16'b001001001, 16'b010010010, 16'b011011011, 16'b100100100, 1'b1, 1'b1);

      reset_run("rst_s4h4", 8'd4, 8'd4, 4'b1010, 1'b0);
      reset_run("rst_s0h4", 8'd0, 8'd4, 4'b1110, 1'b1);

`ifdef SKEW_STIM_NEG_EN
      // skew=-3 hold=2: b k..k+1, a k+3..k+4, done k+5
      do_pulse("neg3", 8'hFD, 8'd2, 7,
               16'b0011000, 16'b0000011, 16'b0011111, 16'b0100000, 1'b0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/skew_stim_gen.md
# skew_stim_gen

Single-clock stimulus generator that emits a pair of pulses, `out_a` and `out_b`, with a programmable rising-edge offset and pulse width. It drives the inputs of skew checkers in gate-level and SDF-annotated benches and on-chip self-test paths. It also flags whether the requested offset falls inside the checker's violation window, so the checker's response can be scored automatically.

## Interface
- `CNT_W`, default 8: width of the `skew` and `hold` operands, in cycles.
- `LIMIT`, default 2: violation window in cycles. `exp_viol` is set when |skew| < `LIMIT`.
- `clk` in 1: the only clock. All logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a pulse pair. Sampled at every edge and accepted only in IDLE.
- `skew` in `CNT_W`: offset from the `out_a` rise to the `out_b` rise. Unsigned unless `SKEW_STIM_NEG_EN` is defined.
- `hold` in `CNT_W`: high time of each output. A value of 0 is treated as 1.
- `out_a` out 1: first pulse. Registered.
- `out_b` out 1: second pulse. Registered.
- `busy` out 1: high from the accept edge until the completion edge.
- `done` out 1: one-cycle completion pulse.
- `exp_viol` out 1: latched at accept and held until the next accept or reset.

## Operation
- FSM states: IDLE, RUN. A single elapsed counter `t` of width `CNT_W+1`.
- Accept edge k is the edge where `start`=1 and state=IDLE. At that edge:
  - `skew` and `hold` are captured into `s` and `h`; `h` = max(`hold`, 1).
  - `t` is cleared to 0, state goes to RUN, `busy`=1, `out_a`=1.
  - `exp_viol` is set to (s < `LIMIT`).
- `skew` and `hold` are ignored at all edges other than accept.
- In RUN, `t` increments every edge.
  - `out_a` is high after edges k .. k+h-1 and falls after edge k+h.
  - `out_b` rises after edge k+s and falls after edge k+s+h.
  - With s=0, both outputs rise and fall together.
  - With s ≥ h, both outputs are low for s-h cycles between the two pulses.
- Completion at edge k+s+h: state goes to IDLE, `busy`=0, `done`=1 for exactly one cycle.
- `start` while RUN is dropped: no queue, no error.
- `start` on the completion edge is not accepted, because state is RUN at that edge. The next accept can be k+s+h+1 at the earliest.
- Arithmetic: s+h ≤ 2·(2^`CNT_W`−1), which fits in `t`. The counter never wraps.

## Timing
- Reset values: all outputs are 0, state is IDLE, `t` is 0.
- `rst` wins over `start` in the same cycle.
- Reset mid-RUN:
  - Both outputs and `busy` are 0 after the reset edge.
  - No `done` is produced, and `exp_viol` is cleared.
- Latency: `out_a` rises at the accept edge, i.e. zero cycles after `start` is sampled.
- Busy duration is s+h cycles. Request-to-request period is at least s+h+1 cycles.
- All outputs come directly from flops, so there is no combinational path from input to output.

## Configuration
- `SKEW_STIM_NEG_EN`
  - Defined: `skew` is signed two's complement.
    - A negative value swaps the roles: `out_b` leads and `out_a` trails by |skew|.
    - s is captured as |skew|.
    - `exp_viol` uses |skew|.
    - The most negative value saturates to 2^(`CNT_W`−1)−1.
  - Undefined: `skew` is unsigned, `out_a` always leads, and the swap logic is absent.

## Structure
- Package `skew_stim_pkg` holds:
  - the state enum (IDLE, RUN);
  - `CNT_W` and `LIMIT` default localparams;
  - an `abs_sat` function used under `SKEW_STIM_NEG_EN`.
- One sub-module, `skew_stim_pulse`, is instantiated twice. It is a registered pulse shaper: given `t`, a rise offset and `h`, it produces a pulse that is high for `t` in [offset, offset+h).
- The top level holds the FSM, the counter, the captures and the `done`/`exp_viol` logic.

## Test plan
- Reset, then idle for 5 cycles: all outputs stay 0; a `start` asserted together with `rst` is not accepted.
- skew=1, hold=3:
  - `out_a` is high for edges k..k+2.
  - `out_b` is high for edges k+1..k+3.
  - `done` fires at k+4.
  - `exp_viol`=1.
- skew=5, hold=2:
  - There is a 3-cycle gap with both outputs low.
  - `done` fires at k+7.
  - `exp_viol`=0.
- skew=0, hold=0:
  - Both outputs are high for exactly one cycle, simultaneously.
  - `done` fires at k+1.
- Back-to-back requests:
  - `start` held high continuously: accepts occur every s+h+1 cycles.
  - `rst` at k+2 of a skew=4, hold=4 run: outputs drop, and no `done` is produced.
- With `SKEW_STIM_NEG_EN`, skew=−3, hold=2:
  - `out_b` rises at k and `out_a` rises at k+3.
  - `exp_viol`=0.
